pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter PC_WIDTH, default 32: width of the program counter and of all target addresses.
REQ-002 Parameter RESET_VECTOR, default 0: PC value loaded by reset.
REQ-003 Parameter INC, default 4: sequential PC increment.
REQ-004 Parameter ALIGN_BITS, default 2: number of PC LSBs that SHALL be zero for an aligned fetch; 0 disables the check.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 stall  input  1  pipeline stall request; holds PC.
REQ-008 imem_ready  input  1  instruction memory accepts the current fetch this cycle.
REQ-009 branch_flag  input  1  redirect request from decode.
REQ-010 branch_target  input  PC_WIDTH  redirect address, valid with branch_flag.
REQ-011 flush  input  1  exception/flush redirect; highest priority.
REQ-012 new_pc  input  PC_WIDTH  flush address, valid with flush.
REQ-013 pc  output  PC_WIDTH  current fetch address, registered.
REQ-014 ce  output  1  instruction memory chip enable, registered.
REQ-015 redirect_pending  output  1  a buffered branch target awaits application.
REQ-016 pc_misaligned  output  1  ce high and pc[ALIGN_BITS-1:0] nonzero; combinational from registers.

Function
REQ-017 Two states: IDLE (ce=0) and RUN (ce=1); ce SHALL equal (state==RUN).
REQ-018 IDLE -> RUN on the first rising clk edge with rst low; pc SHALL remain RESET_VECTOR on that edge, so the first fetch address is RESET_VECTOR.
REQ-019 In IDLE all inputs other than rst SHALL be ignored.
REQ-020 advance = ~stall & imem_ready, evaluated each RUN cycle.
REQ-021 RUN, per edge, first matching rule applies:
  a) flush: pc<=new_pc, pending cleared, regardless of stall/imem_ready/branch_flag.
  b) branch_flag & advance: pc<=branch_target, pending cleared (new target overrides any buffered one).
  c) branch_flag & ~advance: pc held; pending target<=branch_target, pending valid<=1 (overwrites existing pending).
  d) advance & pending valid: pc<=pending target, pending cleared.
  e) advance: pc<=pc+INC, modulo 2^PC_WIDTH (wrap, no carry out).
  f) otherwise: pc, pending unchanged.
REQ-022 Redirect latency: target appears on pc the cycle after the accepting edge; no added bubbles.
REQ-023 redirect_pending SHALL equal the pending valid register.
REQ-024 pc_misaligned SHALL be 0 when ALIGN_BITS=0 or ce=0; it SHALL NOT alter PC sequencing.
REQ-025 branch_target/new_pc SHALL be used as-is, without alignment masking.

Reset
REQ-026 rst high SHALL asynchronously force: state=IDLE, ce=0, pc=RESET_VECTOR, pending valid=0, pending target=0, pc_misaligned=0.
REQ-027 rst asserted mid-operation SHALL discard any pending redirect and in-progress flush.
REQ-028 Reset deassertion SHALL take effect only at a rising clk edge per REQ-018.

Verification
REQ-029 Reset release, stall=0, imem_ready=1, defaults -> ce 0 then 1; pc sequence 0,0,4,8,12.
REQ-030 RUN at pc=0x100, branch_flag=1, branch_target=0x2000, advance=1 for one cycle -> next pc=0x2000, then 0x2004; redirect_pending stays 0.
REQ-031 pc=0x40, stall=1, branch to 0x80 then branch to 0x90 on consecutive cycles, stall released 3 cycles later -> pc held 0x40, redirect_pending=1, after release pc=0x90 then 0x94, redirect_pending=0.
REQ-032 pending valid (0x80), flush=1 new_pc=0x180 with stall=1 -> pc=0x180 next cycle, redirect_pending=0; branch_flag on same cycle ignored.
REQ-033 PC_WIDTH=8, pc=0xFC, advance=1 -> pc=0x00; new_pc=0x02 via flush -> pc_misaligned=1.
REQ-034 rst asserted asynchronously mid-cycle with pending valid -> pc=RESET_VECTOR, ce=0, redirect_pending=0 before the next clk edge.

Source files
------------

// File: rtl/pc_ctrl.sv
// Program counter controller: reset vector fetch, sequential increment,
// branch/flush redirects with a one-entry buffer for branches that arrive while stalled.
module pc_ctrl #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned          INC          = 4,
  parameter int unsigned          ALIGN_BITS   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                imem_ready,
  input  logic                branch_flag,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] new_pc,
  output logic [PC_WIDTH-1:0] pc,
  output logic                ce,
  output logic                redirect_pending,
  output logic                pc_misaligned
);

  localparam logic [PC_WIDTH-1:0] INC_W = PC_WIDTH'(INC);
  // Mask of the low address bits that must be zero; all-zero when ALIGN_BITS is 0.
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                pend_valid_q, pend_valid_d;
  logic [PC_WIDTH-1:0] pend_target_q, pend_target_d;
  logic                advance;

  assign advance = ~stall & imem_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (flush) begin
          pc_d         = new_pc;
          pend_valid_d = 1'b0;
        end else if (branch_flag && advance) begin
          pc_d         = branch_target;
          pend_valid_d = 1'b0;
        end else if (branch_flag) begin
          pend_target_d = branch_target;
          pend_valid_d  = 1'b1;
        end else if (advance && pend_valid_q) begin
          pc_d         = pend_target_q;
          pend_valid_d = 1'b0;
        end else if (advance) begin
          pc_d = pc_q + INC_W;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc               = pc_q;
  assign ce               = (state_q == RUN);
  assign redirect_pending = pend_valid_q;
  assign pc_misaligned    = ce & (|(pc_q & ALIGN_MASK));

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: constant-expectation vector table fed through a scoreboard queue,
// plus hand sequences for asynchronous reset and an 8-bit wrap/alignment instance.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, imem_ready, branch_flag, flush;
  logic [31:0] branch_target, new_pc;
  logic [7:0]  branch_target8, new_pc8;
  logic [31:0] pc;
  logic [7:0]  pc8;
  logic        ce, redirect_pending, pc_misaligned;
  logic        ce8, redirect_pending8, pc_misaligned8;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .flush(flush), .new_pc(new_pc), .pc(pc), .ce(ce),
    .redirect_pending(redirect_pending), .pc_misaligned(pc_misaligned)
  );

  pc_ctrl #(.PC_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .branch_flag(branch_flag), .branch_target(branch_target8),
    .flush(flush), .new_pc(new_pc8), .pc(pc8), .ce(ce8),
    .redirect_pending(redirect_pending8), .pc_misaligned(pc_misaligned8)
  );

  typedef struct {
    logic        stall, rdy, bf;
    logic [31:0] bt;
    logic        fl;
    logic [31:0] np;
    logic        d8;
    logic [31:0] epc;
    logic        ece, epend, emis;
  } vec_t;

  typedef struct {
    logic        d8;
    logic [31:0] pc;
    logic        ce, pend, mis;
    string       tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  function automatic vec_t mk(logic s, logic r, logic bf, logic [31:0] bt, logic fl,
                              logic [31:0] np, logic [31:0] epc, logic ece, logic ep, logic em);
    vec_t v;
    v.stall = s; v.rdy = r; v.bf = bf; v.bt = bt; v.fl = fl; v.np = np; v.d8 = 1'b0;
    v.epc = epc; v.ece = ece; v.epend = ep; v.emis = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sbq.pop_front();
    if (e.d8) begin
      chk({e.tag, ".pc8"},  {24'h0, pc8},      e.pc);
      chk({e.tag, ".ce8"},  32'(ce8),          32'(e.ce));
      chk({e.tag, ".pend8"},32'(redirect_pending8), 32'(e.pend));
      chk({e.tag, ".mis8"}, 32'(pc_misaligned8), 32'(e.mis));
    end else begin
      chk({e.tag, ".pc"},   pc,                e.pc);
      chk({e.tag, ".ce"},   32'(ce),           32'(e.ce));
      chk({e.tag, ".pend"}, 32'(redirect_pending), 32'(e.pend));
      chk({e.tag, ".mis"},  32'(pc_misaligned), 32'(e.mis));
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    stall = v.stall; imem_ready = v.rdy; branch_flag = v.bf; branch_target = v.bt;
    flush = v.fl; new_pc = v.np; branch_target8 = v.bt[7:0]; new_pc8 = v.np[7:0];
    e.d8 = v.d8; e.pc = v.epc; e.ce = v.ece; e.pend = v.epend; e.mis = v.emis; e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1'b0; stall = 1'b0; imem_ready = 1'b1; branch_flag = 1'b0; flush = 1'b0;
    branch_target = '0; new_pc = '0; branch_target8 = '0; new_pc8 = '0;

    //          st rdy bf  bt            fl  np            epc           ce pd mis
    tbl.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,     32'h0,    1, 0, 0)); // 0: first fetch at reset vector
    tbl.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,     32'h4,    1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,     32'h8,    1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,     32'hC,    1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,     1, 32'h100,   32'h100,  1, 0, 0)); // 4
    tbl.push_back(mk(0, 1, 1, 32'h2000,  0, 32'h0,     32'h2000, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,     32'h2004, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,     1, 32'h40,    32'h40,   1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 32'h80,    0, 32'h0,     32'h40,   1, 1, 0)); // 8: buffered while stalled
    tbl.push_back(mk(1, 1, 1, 32'h90,    0, 32'h0,     32'h40,   1, 1, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     32'h40,   1, 1, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     32'h40,   1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,     32'h90,   1, 0, 0)); // 12
    tbl.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,     32'h94,   1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,     32'h94,   1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h80,    0, 32'h0,     32'h94,   1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h300,   1, 32'h180,   32'h180,  1, 0, 0)); // 16: flush beats all
    tbl.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,     32'h184,  1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,     1, 32'h182,   32'h182,  1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,     32'h186,  1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 32'h0,     1, 32'h200,   32'h200,  1, 0, 0)); // 20
    tbl.push_back(mk(1, 1, 1, 32'h300,   0, 32'h0,     32'h200,  1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 32'h400,   0, 32'h0,     32'h400,  1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,     32'h404,  1, 0, 0));

    #2 rst = 1'b1;
    #1;
    chk("reset.pc", pc, 32'h0);
    chk("reset.ce", 32'(ce), 32'h0);
    chk("reset.pend", 32'(redirect_pending), 32'h0);
    chk("reset.mis", 32'(pc_misaligned), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("release.ce_before_edge", 32'(ce), 32'h0);
    #1;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Async reset with a pending redirect, asserted between edges.
    step(mk(1, 1, 1, 32'h80, 0, 32'h0, 32'h404, 1, 1, 0), "arst.setup");
    #3 rst = 1'b1;
    #1;
    chk("arst.pc", pc, 32'h0);
    chk("arst.ce", 32'(ce), 32'h0);
    chk("arst.pend", 32'(redirect_pending), 32'h0);
    chk("arst.mis", 32'(pc_misaligned), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(mk(0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 1, 0, 0), "arst.first");
    step(mk(0, 1, 0, 32'h0, 0, 32'h0, 32'h4, 1, 0, 0), "arst.second");

    // 8-bit instance: wrap at 2^8 and misaligned flush target.
    v = mk(0, 1, 0, 32'h0, 1, 32'hFC, 32'hFC, 1, 0, 0); v.d8 = 1'b1; step(v, "w8.load");
    v = mk(0, 1, 0, 32'h0, 0, 32'h0,  32'h00, 1, 0, 0); v.d8 = 1'b1; step(v, "w8.wrap");
    v = mk(0, 1, 0, 32'h0, 1, 32'h02, 32'h02, 1, 0, 1); v.d8 = 1'b1; step(v, "w8.mis");
    v = mk(1, 1, 0, 32'h0, 0, 32'h0,  32'h02, 1, 0, 1); v.d8 = 1'b1; step(v, "w8.hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
